// File: rtl/if_stage.sv
// rtl/if_stage.sv - single-outstanding instruction fetch stage with redirect and decode handoff
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_RESET = RESET_PC & PC_MASK;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_inflight, pc_inflight_n;
    logic        drop, drop_n;
    logic [31:0] id_pc_n, id_inst_n, fetch_cnt_n;

    assign imem_req_valid = (state == REQ);
    assign id_valid       = (state == OUT);
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= PC_RESET;
            pc_inflight <= 32'h0;
            drop        <= 1'b0;
            id_pc       <= 32'h0;
            id_inst     <= 32'h0;
            fetch_cnt   <= 32'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pc_inflight <= pc_inflight_n;
            drop        <= drop_n;
            id_pc       <= id_pc_n;
            id_inst     <= id_inst_n;
            fetch_cnt   <= fetch_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        pc_inflight_n = pc_inflight;
        drop_n        = drop;
        id_pc_n       = id_pc;
        id_inst_n     = id_inst;
        fetch_cnt_n   = fetch_cnt;

        case (state)
            REQ: begin
                if (imem_req_ready) begin
                    state_n       = WAIT;
                    pc_inflight_n = pc;
                    pc_n          = pc + 32'd4;
                    // A redirect racing the handshake poisons the request just issued
                    drop_n        = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_n = 1'b0;
                    if (drop || redirect_valid) begin
                        state_n = REQ;
                    end else begin
                        state_n   = OUT;
                        id_pc_n   = pc_inflight;
                        id_inst_n = imem_rsp_data;
                    end
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            OUT: begin
                if (id_ready) begin
                    state_n     = REQ;
                    fetch_cnt_n = fetch_cnt + 32'd1;
                end
                if (redirect_valid) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_n = redirect_pc & PC_MASK;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with directed and randomized scenarios
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rdy, input logic rspv, input logic [31:0] rdata,
                          input logic idr, input logic redir, input logic [31:0] rpc);
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rdata;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %0h want 1", imem_req_valid); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %0h want 0", id_valid); end
        n_checks++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %08h want %08h", imem_req_addr, RESET_PC); end
        n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %08h want 0", id_pc); end
        n_checks++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst: got %08h want 0", id_inst); end
        n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_cnt: got %0d want 0", fetch_cnt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        int          accepts = 0;
        int          acc_cyc [3];
        logic [31:0] acc_pc [3];
        logic [31:0] acc_inst [3];
        logic [31:0] issued = 32'h0;
        logic        pend = 1'b0;
        do_reset();
        for (int c = 0; c < 30 && accepts < 3; c++) begin
            set_in(1, pend, mem_word(issued), 1, 0, 0);
            if (id_valid) begin
                acc_pc[accepts] = id_pc; acc_inst[accepts] = id_inst; acc_cyc[accepts] = c; accepts++;
            end
            if (imem_req_valid) issued = imem_req_addr;
            pend = imem_req_valid;
            tick();
        end
        n_checks++; if (accepts != 3) begin n_fail++; $display("FAIL seq_accepts: got %0d want 3", accepts); end
        for (int i = 0; i < accepts; i++) begin
            n_checks++; if (acc_pc[i] !== RESET_PC + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %08h want %08h", i, acc_pc[i], RESET_PC + 32'(4 * i)); end
            n_checks++; if (acc_inst[i] !== mem_word(RESET_PC + 32'(4 * i))) begin n_fail++; $display("FAIL seq_inst[%0d]: got %08h want %08h", i, acc_inst[i], mem_word(RESET_PC + 32'(4 * i))); end
            if (i > 0) begin
                n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 3) begin n_fail++; $display("FAIL seq_spacing[%0d]: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]); end
            end
        end
        n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL seq_fetch_cnt: got %0d want 3", fetch_cnt); end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(RESET_PC), 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            set_in($urandom_range(0, 1), 1, $urandom, 0, 0, 0);
            tick();
            n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0h want 1", i, id_valid); end
            n_checks++; if (id_pc !== RESET_PC) begin n_fail++; $display("FAIL stall_pc[%0d]: got %08h want %08h", i, id_pc, RESET_PC); end
            n_checks++; if (id_inst !== mem_word(RESET_PC)) begin n_fail++; $display("FAIL stall_inst[%0d]: got %08h want %08h", i, id_inst, mem_word(RESET_PC)); end
            n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want 0", i, fetch_cnt); end
        end
        set_in(0, 0, 0, 1, 0, 0); tick();
        n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL stall_accept_cnt: got %0d want 1", fetch_cnt); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept_valid: got %0h want 0", id_valid); end
        n_checks++; if (imem_req_addr !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL stall_next_addr: got %08h want %08h", imem_req_addr, RESET_PC + 32'd4); end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 32'h103); tick();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_still_wait: got %0h want 0", imem_req_valid); end
        set_in(0, 1, mem_word(RESET_PC), 1, 0, 0); tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got %0h want 0", id_valid); end
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rdw_req_valid: got %0h want 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_addr: got %08h want 00000100", imem_req_addr); end
        set_in(0, 0, 0, 1, 0, 0); tick();
        n_checks++; if (id_valid !== 1'b0 || fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL rdw_no_output: got valid %0h cnt %0d want 0 0", id_valid, fetch_cnt); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(RESET_PC), 1, 1, 32'h200); tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_no_valid: got %0h want 0", id_valid); end
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_req_valid: got %0h want 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_addr: got %08h want 00000200", imem_req_addr); end
    endtask

    task automatic test_redirect_req();
        do_reset();
        set_in(0, 0, 0, 0, 1, 32'h88); tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h88) begin n_fail++; $display("FAIL rdq_stay: got valid %0h addr %08h want 1 00000088", imem_req_valid, imem_req_addr); end
        set_in(1, 0, 0, 0, 1, 32'h37); tick();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdq_to_wait: got %0h want 0", imem_req_valid); end
        set_in(0, 1, mem_word(32'h88), 1, 0, 0); tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdq_dropped: got %0h want 0", id_valid); end
        n_checks++; if (imem_req_addr !== 32'h34) begin n_fail++; $display("FAIL rdq_addr: got %08h want 00000034", imem_req_addr); end
    endtask

    task automatic test_redirect_out();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(RESET_PC), 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 1, 32'h400); tick();
        n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL rdo_count: got %0d want 1", fetch_cnt); end
        n_checks++; if (id_valid !== 1'b0 || imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL rdo_addr: got valid %0h addr %08h want 0 00000400", id_valid, imem_req_addr); end
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(32'h400), 0, 0, 0); tick();
        n_checks++; if (id_pc !== 32'h400 || id_inst !== mem_word(32'h400)) begin n_fail++; $display("FAIL rdo_present: got pc %08h inst %08h want 00000400 %08h", id_pc, id_inst, mem_word(32'h400)); end
        set_in(0, 0, 0, 0, 1, 32'h500); tick();
        n_checks++; if (fetch_cnt !== 32'd1 || id_valid !== 1'b0 || imem_req_addr !== 32'h500) begin n_fail++; $display("FAIL rdo_noaccept: got cnt %0d valid %0h addr %08h want 1 0 00000500", fetch_cnt, id_valid, imem_req_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(0, 0, 0, 0, 1, 32'hFFFF_FFFE); tick();
        n_checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: got %08h want fffffffc", imem_req_addr); end
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(32'hFFFF_FFFC), 0, 0, 0); tick();
        n_checks++; if (id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id_pc: got %08h want fffffffc", id_pc); end
        set_in(0, 0, 0, 1, 0, 0); tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got valid %0h addr %08h want 1 00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, mem_word(RESET_PC), 1, 0, 0); tick();
        set_in(0, 0, 0, 1, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got req %0h id %0h want 1 0", imem_req_valid, id_valid); end
        n_checks++; if (fetch_cnt !== 32'd0 || imem_req_addr !== RESET_PC || id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL rmid_values: got cnt %0d addr %08h pc %08h inst %08h want zeros", fetch_cnt, imem_req_addr, id_pc, id_inst); end
        tick();
        rst_n = 1'b1;
        set_in(0, 1, mem_word(RESET_PC + 32'd4), 1, 0, 0); tick();
        n_checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_stale: got id %0h req %0h addr %08h want 0 1 %08h", id_valid, imem_req_valid, imem_req_addr, RESET_PC); end
        set_in(1, 0, 0, 1, 0, 0); tick();
        set_in(0, 1, mem_word(RESET_PC), 0, 0, 0); tick();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin n_fail++; $display("FAIL rmid_restart: got id %0h pc %08h want 1 %08h", id_valid, id_pc, RESET_PC); end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    // Transaction-level model: next fetch address, one outstanding request, one presented instruction
    task automatic test_random();
        logic [31:0] exp_fetch = RESET_PC, pend_addr = 0, show_pc = 0, exp_cnt = 0;
        logic        pend = 0, stale = 0, showing = 0, m_req;
        logic        rdy, rspv, idr, redir;
        logic [31:0] rpc;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            m_req = !pend && !showing;
            n_checks++; if (imem_req_valid !== m_req) begin n_fail++; $display("FAIL rnd_req_valid@%0d: got %0h want %0h", c, imem_req_valid, m_req); end
            n_checks++; if (id_valid !== showing) begin n_fail++; $display("FAIL rnd_id_valid@%0d: got %0h want %0h", c, id_valid, showing); end
            n_checks++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, fetch_cnt, exp_cnt); end
            if (m_req) begin
                n_checks++; if (imem_req_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr@%0d: got %08h want %08h", c, imem_req_addr, exp_fetch); end
            end
            if (showing) begin
                n_checks++; if (id_pc !== show_pc || id_inst !== mem_word(show_pc)) begin n_fail++; $display("FAIL rnd_present@%0d: got pc %08h inst %08h want %08h %08h", c, id_pc, id_inst, show_pc, mem_word(show_pc)); end
            end
            rdy   = 1'($urandom_range(0, 1));
            rspv  = 1'($urandom_range(0, 1));
            idr   = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 7) == 0);
            rpc   = $urandom;
            set_in(rdy, rspv, pend ? mem_word(pend_addr) : $urandom, idr, redir, rpc);
            tick();
            if (m_req && rdy) begin
                pend = 1; pend_addr = exp_fetch; stale = redir;
                if (!redir) exp_fetch = exp_fetch + 32'd4;
            end else if (pend && rspv) begin
                pend = 0;
                if (!stale && !redir) begin showing = 1; show_pc = pend_addr; end
            end else if (pend && redir) begin
                stale = 1;
            end else if (showing && (idr || redir)) begin
                if (idr) exp_cnt = exp_cnt + 32'd1;
                showing = 0;
            end
            if (redir) exp_fetch = rpc & 32'hFFFF_FFFC;
        end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_req();
        test_redirect_out();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
